// File: rtl/audio_s00_axi_regs.sv
// -----------------------------------------------------------------------------
// audio_s00_axi_regs
//
// AXI4-Lite slave register block for the audio IP. Four 32-bit read/write
// registers (CTRL, VOLUME, RATE_DIV, SCRATCH) sit at words 0-3 of an 8-word
// window; words 4-7 answer with SLVERR. Register contents and one-cycle
// write pulses are exported to the audio core.
//
// Ports
//   ACLK, ARESETN            : clock (rising edge), asynchronous active-low reset
//   S_AXI_AW*                : write address channel (AWPROT ignored)
//   S_AXI_W*                 : write data channel with byte strobes
//   S_AXI_B*                 : write response channel
//   S_AXI_AR*                : read address channel (ARPROT ignored)
//   S_AXI_R*                 : read data channel
//   reg_ctrl .. reg_scratch  : current register values
//   reg_wr_pulse[n]          : high for one cycle after register n is written
// -----------------------------------------------------------------------------
module audio_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [31:0]                       reg_ctrl,
    output logic [31:0]                       reg_volume,
    output logic [31:0]                       reg_rate_div,
    output logic [31:0]                       reg_scratch,
    output logic [3:0]                        reg_wr_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge new data into an old register value, one byte per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_v[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Registers
    logic        run_r;          // 0 during reset and the first edge after; gates all READYs
    logic        aw_held_r;
    logic [4:0]  aw_addr_r;
    logic        w_held_r;
    logic [31:0] w_data_r;
    logic [3:0]  w_strb_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;
    logic        rvalid_r;
    logic [1:0]  rresp_r;
    logic [31:0] rdata_r;
    logic [31:0] ctrl_r;
    logic [31:0] volume_r;
    logic [31:0] rate_div_r;
    logic [31:0] scratch_r;
    logic [3:0]  wr_pulse_r;

    // Combinational helpers
    logic        awready_s;
    logic        wready_s;
    logic        arready_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        ar_hs_s;
    logic        commit_s;
    logic [4:0]  wr_addr_s;
    logic [31:0] wr_data_s;
    logic [3:0]  wr_strb_s;
    logic        unused_s;

    // READYs depend only on state registers, never on VALID/READY inputs.
    assign awready_s = run_r & ~aw_held_r & ~bvalid_r;
    assign wready_s  = run_r & ~w_held_r  & ~bvalid_r;
    assign arready_s = run_r & ~rvalid_r;

    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Handshake detection and selection of the effective write address/data.
    always_comb begin
        aw_hs_s  = S_AXI_AWVALID & awready_s;
        w_hs_s   = S_AXI_WVALID & wready_s;
        ar_hs_s  = S_AXI_ARVALID & arready_s;
        // A write commits as soon as both halves are known, held or arriving now.
        commit_s = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
        if (aw_hs_s) begin
            wr_addr_s = S_AXI_AWADDR;
        end else begin
            wr_addr_s = aw_addr_r;
        end
        if (w_hs_s) begin
            wr_data_s = S_AXI_WDATA;
            wr_strb_s = S_AXI_WSTRB;
        end else begin
            wr_data_s = w_data_r;
            wr_strb_s = w_strb_r;
        end
    end

    // Write path: AW/W holding, commit into registers, B response, pulses.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run_r      <= 1'b0;
            aw_held_r  <= 1'b0;
            aw_addr_r  <= 5'd0;
            w_held_r   <= 1'b0;
            w_data_r   <= 32'h0000_0000;
            w_strb_r   <= 4'h0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            ctrl_r     <= 32'h0000_0000;
            volume_r   <= 32'h0000_0000;
            rate_div_r <= 32'h0000_0000;
            scratch_r  <= 32'h0000_0000;
            wr_pulse_r <= 4'b0000;
        end else begin
            run_r      <= 1'b1;
            wr_pulse_r <= 4'b0000;
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                if (!wr_addr_s[4]) begin
                    bresp_r    <= RESP_OKAY;
                    wr_pulse_r <= 4'b0001 << wr_addr_s[3:2];
                    case (wr_addr_s[3:2])
                        2'd0:    ctrl_r     <= apply_strb(ctrl_r, wr_data_s, wr_strb_s);
                        2'd1:    volume_r   <= apply_strb(volume_r, wr_data_s, wr_strb_s);
                        2'd2:    rate_div_r <= apply_strb(rate_div_r, wr_data_s, wr_strb_s);
                        2'd3:    scratch_r  <= apply_strb(scratch_r, wr_data_s, wr_strb_s);
                        default: ctrl_r     <= ctrl_r;
                    endcase
                end else begin
                    bresp_r <= RESP_SLVERR;
                end
            end else begin
                if (aw_hs_s) begin
                    aw_held_r <= 1'b1;
                    aw_addr_r <= S_AXI_AWADDR;
                end
                if (w_hs_s) begin
                    w_held_r <= 1'b1;
                    w_data_r <= S_AXI_WDATA;
                    w_strb_r <= S_AXI_WSTRB;
                end
                if (bvalid_r && S_AXI_BREADY) begin
                    bvalid_r <= 1'b0;
                end
            end
        end
    end

    // Read path: one-cycle latency; registers sampled before any same-edge write.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= 32'h0000_0000;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            if (!S_AXI_ARADDR[4]) begin
                rresp_r <= RESP_OKAY;
                case (S_AXI_ARADDR[3:2])
                    2'd0:    rdata_r <= ctrl_r;
                    2'd1:    rdata_r <= volume_r;
                    2'd2:    rdata_r <= rate_div_r;
                    2'd3:    rdata_r <= scratch_r;
                    default: rdata_r <= 32'h0000_0000;
                endcase
            end else begin
                rresp_r <= RESP_SLVERR;
                rdata_r <= 32'h0000_0000;
            end
        end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = awready_s;
    assign S_AXI_WREADY  = wready_s;
    assign S_AXI_ARREADY = arready_s;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign reg_ctrl      = ctrl_r;
    assign reg_volume    = volume_r;
    assign reg_rate_div  = rate_div_r;
    assign reg_scratch   = scratch_r;
    assign reg_wr_pulse  = wr_pulse_r;

endmodule

// File: tb/tb_audio_s00_axi_regs.sv
// -----------------------------------------------------------------------------
// tb_audio_s00_axi_regs
//
// Directed bench for audio_s00_axi_regs: reset state, sequential writes and
// reads, AW/W ordering, byte strobes, error window, backpressure, read/write
// collision and reset in the middle of a write. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_audio_s00_axi_regs;

    logic        ACLK;
    logic        ARESETN;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [31:0] reg_ctrl;
    logic [31:0] reg_volume;
    logic [31:0] reg_rate_div;
    logic [31:0] reg_scratch;
    logic [3:0]  reg_wr_pulse;

    int total = 0;
    int bad   = 0;
    int b_cnt = 0;

    audio_s00_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_ctrl(reg_ctrl), .reg_volume(reg_volume), .reg_rate_div(reg_rate_div),
        .reg_scratch(reg_scratch), .reg_wr_pulse(reg_wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Count completed B handshakes.
    always @(posedge ACLK) begin
        if (S_AXI_BVALID && S_AXI_BREADY) b_cnt <= b_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // One write; W is presented w_lead cycles before AW (0 = same cycle).
    // BREADY is withheld for b_hold cycles once BVALID appears.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input int b_hold,
                            output logic [1:0] resp, output logic [3:0] pulse);
        int   cyc;
        logic aw_acc;
        logic w_acc;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        S_AXI_AWVALID = (w_lead == 0);
        S_AXI_BREADY  = (b_hold == 0);
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 50) begin
            aw_acc = S_AXI_AWVALID & S_AXI_AWREADY;
            w_acc  = S_AXI_WVALID & S_AXI_WREADY;
            tick();
            cyc++;
            if (aw_acc) S_AXI_AWVALID = 1'b0;
            if (w_acc)  S_AXI_WVALID  = 1'b0;
            if (cyc == w_lead) S_AXI_AWVALID = 1'b1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("bvalid_seen", S_AXI_BVALID, 1'b1);
        resp  = S_AXI_BRESP;
        pulse = reg_wr_pulse;
        for (int i = 0; i < b_hold; i++) begin
            tick();
            chk("bp_bvalid", S_AXI_BVALID, 1'b1);
            chk("bp_bresp", S_AXI_BRESP, resp);
            chk("bp_awready", S_AXI_AWREADY, 1'b0);
            chk("bp_wready", S_AXI_WREADY, 1'b0);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        chk("bvalid_clear", S_AXI_BVALID, 1'b0);
    endtask

    // One read; RREADY is withheld for r_hold cycles once RVALID appears.
    task automatic do_read(input logic [4:0] a, input int r_hold,
                           output logic [31:0] data, output logic [1:0] resp);
        int   cyc;
        logic ar_acc;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = (r_hold == 0);
        cyc = 0;
        while (!S_AXI_RVALID && cyc < 50) begin
            ar_acc = S_AXI_ARVALID & S_AXI_ARREADY;
            tick();
            cyc++;
            if (ar_acc) S_AXI_ARVALID = 1'b0;
        end
        S_AXI_ARVALID = 1'b0;
        chk("rvalid_seen", S_AXI_RVALID, 1'b1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        for (int i = 0; i < r_hold; i++) begin
            tick();
            chk("bp_rvalid", S_AXI_RVALID, 1'b1);
            chk("bp_rdata", S_AXI_RDATA, data);
            chk("bp_arready", S_AXI_ARREADY, 1'b0);
        end
        S_AXI_RREADY = 1'b1;
        tick();
        chk("rvalid_clear", S_AXI_RVALID, 1'b0);
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [31:0] data;
        int          b_before;

        ARESETN = 1'b0;
        S_AXI_AWADDR = 5'd0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = 5'd0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_ctrl", reg_ctrl, 32'h0);
        chk("rst_scratch", reg_scratch, 32'h0);
        chk("rst_bvalid", S_AXI_BVALID, 1'b0);
        chk("rst_rvalid", S_AXI_RVALID, 1'b0);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_pulse", reg_wr_pulse, 4'h0);
        chk("rst_awready", S_AXI_AWREADY, 1'b0);
        chk("rst_wready", S_AXI_WREADY, 1'b0);
        chk("rst_arready", S_AXI_ARREADY, 1'b0);
        ARESETN = 1'b1;
        tick();

        // Sequential writes 1..4 then reads
        for (int i = 0; i < 4; i++) begin
            do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, resp, pulse);
            chk("seq_bresp", resp, 2'b00);
            chk("seq_pulse", pulse, 4'b0001 << i);
            chk("seq_pulse_gone", reg_wr_pulse, 4'b0000);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(5'(4 * i), 0, data, resp);
            chk("seq_rdata", data, 32'(i + 1));
            chk("seq_rresp", resp, 2'b00);
        end

        // W three cycles ahead of AW
        b_before = b_cnt;
        do_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, resp, pulse);
        tick(); tick();
        chk("wfirst_rate_div", reg_rate_div, 32'hDEADBEEF);
        chk("wfirst_bcount", b_cnt - b_before, 1);
        chk("wfirst_pulse", pulse, 4'b0100);

        // AW and W in the same cycle (clear first so the value must be rewritten)
        do_write(5'h08, 32'h0000_0000, 4'hF, 0, 0, resp, pulse);
        chk("clear_rate_div", reg_rate_div, 32'h0);
        b_before = b_cnt;
        do_write(5'h08, 32'hDEADBEEF, 4'hF, 0, 0, resp, pulse);
        tick(); tick();
        chk("same_rate_div", reg_rate_div, 32'hDEADBEEF);
        chk("same_bcount", b_cnt - b_before, 1);

        // Byte strobes
        do_write(5'h0C, 32'h11223344, 4'hF, 0, 0, resp, pulse);
        do_write(5'h0C, 32'hAABBCCDD, 4'b0101, 0, 0, resp, pulse);
        chk("strb_scratch", reg_scratch, 32'h11BB33DD);
        chk("strb_pulse", pulse, 4'b1000);

        // Error window
        do_write(5'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, pulse);
        chk("err_bresp", resp, 2'b10);
        chk("err_pulse", pulse, 4'b0000);
        chk("err_ctrl", reg_ctrl, 32'h1);
        chk("err_volume", reg_volume, 32'h2);
        chk("err_rate_div", reg_rate_div, 32'hDEADBEEF);
        chk("err_scratch", reg_scratch, 32'h11BB33DD);
        do_read(5'h1C, 0, data, resp);
        chk("err_rdata", data, 32'h0);
        chk("err_rresp", resp, 2'b10);

        // Backpressure on B and R
        do_write(5'h08, 32'h12345678, 4'hF, 0, 5, resp, pulse);
        chk("bp_wr_bresp", resp, 2'b00);
        do_read(5'h08, 4, data, resp);
        chk("bp_rd_rdata", data, 32'h12345678);

        // Read and write of VOLUME committing in the same cycle
        chk("col_awready", S_AXI_AWREADY, 1'b1);
        chk("col_wready", S_AXI_WREADY, 1'b1);
        chk("col_arready", S_AXI_ARREADY, 1'b1);
        S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 5'h04;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("col_rvalid", S_AXI_RVALID, 1'b1);
        chk("col_rdata_old", S_AXI_RDATA, 32'h2);
        chk("col_bvalid", S_AXI_BVALID, 1'b1);
        chk("col_volume", reg_volume, 32'h55);
        tick();
        S_AXI_RREADY = 1'b0;
        do_read(5'h04, 0, data, resp);
        chk("col_rdata_new", data, 32'h55);

        // Reset after AW accepted, before W
        S_AXI_AWADDR = 5'h04; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("mid_aw_held", S_AXI_AWREADY, 1'b0);
        ARESETN = 1'b0;
        #1;
        chk("mid_ctrl", reg_ctrl, 32'h0);
        chk("mid_volume", reg_volume, 32'h0);
        chk("mid_rate_div", reg_rate_div, 32'h0);
        chk("mid_scratch", reg_scratch, 32'h0);
        chk("mid_bvalid", S_AXI_BVALID, 1'b0);
        chk("mid_awready", S_AXI_AWREADY, 1'b0);
        chk("mid_wready", S_AXI_WREADY, 1'b0);
        chk("mid_arready", S_AXI_ARREADY, 1'b0);
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        chk("post_bvalid", S_AXI_BVALID, 1'b0);
        do_write(5'h00, 32'h7, 4'hF, 3, 0, resp, pulse);
        chk("post_pulse", pulse, 4'b0001);
        do_read(5'h00, 0, data, resp);
        chk("post_rdata", data, 32'h7);
        chk("post_volume", reg_volume, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
